// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch core.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package stopwatch_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam int DEF_TICK_DIV = 5000000;
  localparam int DEF_SCAN_DIV = 50000;

  // Bits needed for a counter running 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int TICK_W = cnt_w(DEF_TICK_DIV);
  localparam int SCAN_W = cnt_w(DEF_SCAN_DIV);

  // Tens-of-seconds and tens-of-minutes digits wrap at 6.
  function automatic int digit_mod(input int k);
    return (k == 2 || k == 4) ? 6 : 10;
  endfunction

endpackage

// File: rtl/sseg_decoder.sv
// BCD to active-low seven-segment decode.
// Anything outside 0-9 shows a dash.
module sseg_decoder
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup; no state.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_mux.sv
// Stopwatch core: BCD count chain, lap freeze, overflow,
// and a scanned common-anode seven-segment driver.
module stopwatch_mux
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int SCAN_DIV   = DEF_SCAN_DIV,
  parameter int NUM_DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start_stop,
  input  logic                  lap,
  input  logic                  clear,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  running,
  output logic                  lap_active,
  output logic                  overflow
);

  localparam int PW = cnt_w(TICK_DIV);
  localparam int SW = cnt_w(SCAN_DIV);
  localparam int IW = cnt_w(NUM_DIGITS);

  localparam logic [PW-1:0] P_TOP = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_TOP = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_TOP = IW'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [IW-1:0] idx_q, idx_d;
  digits_t       dig_q, dig_d;
  digits_t       lap_q, lap_d;
  digits_t       disp;
  logic          run_q, run_d;
  logic          la_q, la_d;
  logic          ov_q, ov_d;
  logic          tick;
  logic          cy;

  logic [6:0]            seg_q, seg_d, seg_n;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            bcd;

  // Tenth-second strobe; prescaler only moves while running.
  always_comb begin
    tick    = run_q && (presc_q == P_TOP);
    run_d   = run_q ^ start_stop;
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (run_q) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  // Ripple the tick through the BCD chain; handle lap and clear.
  always_comb begin
    dig_d = dig_q;
    lap_d = lap_q;
    la_d  = la_q;
    ov_d  = ov_q;
    cy    = tick;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (cy) begin
        if (dig_q[k] == 4'(digit_mod(k) - 1)) begin
          dig_d[k] = '0;
        end else begin
          dig_d[k] = dig_q[k] + 4'd1;
          cy       = 1'b0;
        end
      end
    end
    if (cy) ov_d = 1'b1;
    if (lap) begin
      if (!la_q) begin
        lap_d = dig_q;
        la_d  = 1'b1;
      end else begin
        la_d  = 1'b0;
      end
    end
    if (clear) begin
      dig_d = '0;
      lap_d = '0;
      la_d  = 1'b0;
      ov_d  = 1'b0;
    end
  end

  // Free-running scan timer and digit index.
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == S_TOP) begin
      scan_d = '0;
      idx_d  = (idx_q == I_TOP) ? '0 : idx_q + 1'b1;
    end
  end

  // Pick the digit under the scan and form the next pin values.
  always_comb begin
    disp = la_q ? lap_q : dig_q;
    bcd  = disp[idx_q];
    an_d = ~(NUM_DIGITS'(1) << idx_q);
    seg_d = seg_n;
    dp_d = 1'b1;
    if (idx_q == IW'(1) || idx_q == IW'(3)) dp_d = 1'b0;
    if (NUM_DIGITS > 5 && idx_q == IW'(5)) dp_d = 1'b0;
  end

  sseg_decoder u_dec (
    .bcd (bcd),
    .seg (seg_n)
  );

  // All state, including the pin registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      lap_q   <= '0;
      run_q   <= 1'b0;
      la_q    <= 1'b0;
      ov_q    <= 1'b0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= '1;
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      lap_q   <= lap_d;
      run_q   <= run_d;
      la_q    <= la_d;
      ov_q    <= ov_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign running    = run_q;
  assign lap_active = la_q;
  assign overflow   = ov_q;

endmodule

// File: tb/tb_stopwatch_mux.sv
// Randomised and directed bench for stopwatch_mux.
// Reference model counts whole tenths of a second.
module tb_stopwatch_mux;

  localparam int TD   = 4;
  localparam int SD   = 2;
  localparam int ND   = 4;
  localparam int MAXC = 6000;
  localparam int CAP  = 30000;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       running;
  logic       lap_active;
  logic       overflow;

  stopwatch_mux #(
    .TICK_DIV   (TD),
    .SCAN_DIV   (SD),
    .NUM_DIGITS (ND)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  logic [6:0] code [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int   m_cnt, m_ph, m_lapv, m_edges;
  bit   m_run, m_la, m_ov;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [3:0] e_an;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int dig_of(input int v, input int k);
    case (k)
      0:       return v % 10;
      1:       return (v / 10) % 10;
      2:       return (v / 100) % 6;
      default: return v / 600;
    endcase
  endfunction

  function automatic logic [3:0] inv_seg(input logic [6:0] s);
    for (int i = 0; i < 10; i++)
      if (code[i] == s) return 4'(i);
    return 4'hF;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_ph = 0; m_lapv = 0; m_edges = 0;
    m_run = 0; m_la = 0; m_ov = 0;
    e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
  endtask

  // One clock with the given pulses, model update, then check.
  task automatic step(input bit ss, input bit lp, input bit cl);
    int idx, dv;
    bit tk;
    idx   = (m_edges / SD) % ND;
    dv    = m_la ? m_lapv : m_cnt;
    e_an  = ~(4'b0001 << idx);
    e_seg = code[dig_of(dv, idx)];
    e_dp  = !(idx == 1 || idx == 3);
    tk    = m_run && (m_ph == TD - 1);
    if (cl) begin
      m_cnt = 0; m_ph = 0; m_lapv = 0; m_la = 0; m_ov = 0;
    end else begin
      if (lp) begin
        if (!m_la) begin
          m_lapv = m_cnt;
          m_la   = 1;
        end else begin
          m_la = 0;
        end
      end
      if (m_run) m_ph = tk ? 0 : m_ph + 1;
      if (tk) begin
        m_cnt++;
        if (m_cnt == MAXC) begin
          m_cnt = 0;
          m_ov  = 1;
        end
      end
    end
    if (ss) m_run = !m_run;
    m_edges++;
    start_stop = ss; lap = lp; clear = cl;
    @(posedge clock);
    #1;
    start_stop = 0; lap = 0; clear = 0;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("running", 32'(running), 32'(m_run));
    chk("lap_active", 32'(lap_active), 32'(m_la));
    chk("overflow", 32'(overflow), 32'(m_ov));
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask

  task automatic run_until(input int target);
    int n;
    n = 0;
    while (m_cnt != target && n < CAP) begin
      step(0, 0, 0);
      n++;
    end
    if (m_cnt != target) chk("run_until_timeout", 32'(m_cnt), 32'(target));
  endtask

  // Assemble the shown digits from one full scan of the pins.
  task automatic read_display(output logic [15:0] v);
    v = 16'hFFFF;
    repeat (ND * SD) begin
      step(0, 0, 0);
      for (int i = 0; i < ND; i++)
        if (!an[i]) v[i*4 +: 4] = inv_seg(seg);
    end
  endtask

  logic [15:0] shown;
  int          r;

  initial begin
    reset_n = 0; start_stop = 0; lap = 0; clear = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1;

    step(1, 0, 0);
    idle(13);

    #2;
    reset_n = 0;
    #1;
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_lap_active", 32'(lap_active), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1;
    model_reset();
    idle(8);

    step(1, 0, 0);
    run_until(600);
    step(1, 0, 0);
    read_display(shown);
    chk("carry_1m", 32'(shown), 32'h1000);

    step(0, 0, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    idle(20);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    read_display(shown);
    chk("resume_tick", 32'(shown), 32'h0001);

    step(0, 0, 1);
    step(1, 0, 0);
    run_until(123);
    step(0, 1, 0);
    run_until(173);
    step(1, 0, 0);
    read_display(shown);
    chk("lap_frozen", 32'(shown), 32'h0123);
    chk("lap_on", 32'(lap_active), 32'h1);
    step(0, 1, 0);
    read_display(shown);
    chk("lap_release", 32'(shown), 32'h0173);

    step(0, 0, 1);
    step(1, 0, 0);
    run_until(MAXC - 1);
    step(1, 0, 0);
    read_display(shown);
    chk("near_max", 32'(shown), 32'h9599);
    step(1, 0, 0);
    run_until(0);
    step(1, 0, 0);
    read_display(shown);
    chk("wrap_zero", 32'(shown), 32'h0000);
    chk("ovf_set", 32'(overflow), 32'h1);
    idle(10);
    chk("ovf_sticky", 32'(overflow), 32'h1);

    step(1, 0, 0);
    r = 0;
    while (!(m_run && m_ph == TD - 1) && r < 20) begin
      step(0, 0, 0);
      r++;
    end
    step(1, 1, 1);
    chk("sim_running", 32'(running), 32'h0);
    chk("sim_lap", 32'(lap_active), 32'h0);
    chk("sim_ovf", 32'(overflow), 32'h0);
    read_display(shown);
    chk("sim_digits", 32'(shown), 32'h0000);

    step(1, 0, 0);
    repeat (3000) begin
      r = int'($urandom_range(0, 199));
      step(r < 4, r >= 4 && r < 9, r == 9);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
